rr_arbiter8: RTL



---
 rtl/rr_arbiter8.sv | 88 ++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with held ownership, registered one-hot and binary grant outputs,
// and an optional cap on how long one owner may keep the grant.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);
  localparam bit         HoldEn    = (MAX_HOLD != 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       rel_drop;
  logic       rel_max;

  // Walk from the farthest offset back to ptr so the nearest requester is assigned last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    rel_drop = ~req[gnt_idx];
    rel_max  = HoldEn && (hold_q == HoldLimit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q   <= StGrant;
            gnt       <= 8'b1 << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_q    <= 8'd1;
          end
        end
        StGrant: begin
          if (done || rel_drop || rel_max) begin
            state_q   <= StIdle;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr_q     <= gnt_idx + 3'd1;
            // Flag only a purely forced release.
            timeout   <= rel_max && !done && !rel_drop;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
